cw_descrambler: RTL and testbench



---
 rtl/cw_pkg.sv | 29 ++
 rtl/cw_cam16.sv | 38 +++
 rtl/cw_descrambler.sv | 132 +++++++++++++
 tb/tb_cw_descrambler.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cw_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : cw_pkg
//  Purpose  : Shared definitions for the counter-XOR-ROM codeword link.
//             Holds the 16-entry codebook (the same table that fills the
//             transmitter ROM16x8), the lock-FSM state encoding and the
//             keystream width.
//  Revision : 1.0  initial release
// ============================================================================
package cw_pkg;

   // Keystream (and data index) width
   localparam int KW = 4;

   // Codebook: entry i is the codeword that carries index i.
   // All entries are unique so the inverse lookup has at most one hit.
   localparam logic [7:0] CODEBOOK [0:15] = '{
      8'h1B, 8'h2D, 8'h36, 8'h47, 8'h59, 8'h6A, 8'h74, 8'h8E,
      8'h93, 8'hA5, 8'hB8, 8'hC6, 8'hD1, 8'hE3, 8'hF2, 8'h0F
   };

   // Lock FSM encoding
   typedef enum logic [0:0] {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/cw_cam16.sv
`default_nettype none
// ============================================================================
//  Module   : cw_cam16
//  Purpose  : Combinational inverse codebook lookup (16-entry CAM).
//  Ports    : code_i   [7:0]    codeword to search for
//             match_o           codeword found in the codebook
//             idx_o    [KW-1:0] index of the matching entry (0 when no match)
//  Revision : 1.0  initial release
// ============================================================================
module cw_cam16
   import cw_pkg::*;
(
   input  logic [7:0]    code_i,
   output logic          match_o,
   output logic [KW-1:0] idx_o
);

   logic [15:0] hit_w;

   for (genvar i = 0; i < 16; i++) begin : g_entry
      assign hit_w[i] = (code_i == CODEBOOK[i]);
   end

   // Entries are unique, so OR-ing the indices of all hits yields the index
   // of the single hit without a priority chain.
   always_comb begin
      idx_o = '0;
      for (int i = 0; i < 16; i++) begin
         if (hit_w[i]) begin
            idx_o = idx_o | KW'(i);
         end
      end
   end

   assign match_o = |hit_w;

endmodule
`default_nettype wire

// File: rtl/cw_descrambler.sv
`default_nettype none
// ============================================================================
//  Module   : cw_descrambler
//  Purpose  : Receive-side codeword descrambler. Inverse-maps each received
//             codeword to a 4-bit index, removes the counter keystream and
//             tracks keystream alignment with a HUNT/LOCK FSM.
//  Params   : MAXERR  consecutive invalid codewords in LOCK before HUNT (1..15)
//             ECW     width of the saturating error counter
//  Ports    : dec_clk, dec_rst (async, active-high)
//             dec_in[7:0], dec_vld, dec_sync         received beat
//             dec_out[3:0], dec_ovld, dec_err         registered beat result
//             dec_locked                              FSM is in LOCK
//             dec_errcnt[ECW-1:0]                     total invalid codewords
//  Revision : 1.0  initial release
// ============================================================================
module cw_descrambler
   import cw_pkg::*;
#(
   parameter int MAXERR = 4,
   parameter int ECW    = 8
) (
   input  logic           dec_clk,
   input  logic           dec_rst,
   input  logic [7:0]     dec_in,
   input  logic           dec_vld,
   input  logic           dec_sync,
   output logic [KW-1:0]  dec_out,
   output logic           dec_ovld,
   output logic           dec_err,
   output logic           dec_locked,
   output logic [ECW-1:0] dec_errcnt
);

   logic          match_w;
   logic [KW-1:0] idx_w;

   cw_cam16 u_cam (
      .code_i  (dec_in),
      .match_o (match_w),
      .idx_o   (idx_w)
   );

   state_t         state_q;
   logic [KW-1:0]  k_q;
   logic [3:0]     run_q;
   logic [ECW-1:0] errcnt_q;
   logic [KW-1:0]  out_q;
   logic           ovld_q;
   logic           err_q;

   // Next-value helpers
   logic [KW-1:0]  k_d;
   logic [3:0]     run_d;
   logic [ECW-1:0] errcnt_d;
   logic           run_hit_w;

   assign k_d       = k_q + KW'(1);
   assign run_d     = run_q + 4'd1;
   assign errcnt_d  = (&errcnt_q) ? errcnt_q : errcnt_q + ECW'(1);
   // This invalid beat completes the run of MAXERR consecutive errors
   assign run_hit_w = (run_d == 4'(MAXERR));

   always_ff @(posedge dec_clk or posedge dec_rst) begin
      if (dec_rst) begin
         state_q  <= HUNT;
         k_q      <= '0;
         run_q    <= '0;
         errcnt_q <= '0;
         out_q    <= '0;
         ovld_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         // Pulses default low; dec_out holds its last value between beats
         ovld_q <= 1'b0;
         err_q  <= 1'b0;
         if (dec_vld) begin
            case (state_q)
               HUNT: begin
                  // Only sync beats are looked at while hunting
                  if (dec_sync) begin
                     if (match_w) begin
                        out_q   <= idx_w;          // K = 0 on the sync beat
                        ovld_q  <= 1'b1;
                        k_q     <= KW'(1);
                        run_q   <= '0;
                        state_q <= LOCK;
                     end else begin
                        err_q    <= 1'b1;
                        errcnt_q <= errcnt_d;
                     end
                  end
               end
               LOCK: begin
                  ovld_q <= 1'b1;
                  if (match_w) begin
                     run_q <= '0;
                     if (dec_sync) begin
                        // Re-align: this beat was sent with counter 0
                        out_q <= idx_w;
                        k_q   <= KW'(1);
                     end else begin
                        out_q <= idx_w ^ k_q;
                        k_q   <= k_d;
                     end
                  end else begin
                     out_q    <= '0;
                     err_q    <= 1'b1;
                     errcnt_q <= errcnt_d;
                     if (run_hit_w) begin
                        state_q <= HUNT;
                        k_q     <= '0;
                        run_q   <= '0;
                     end else begin
                        k_q   <= k_d;
                        run_q <= run_d;
                     end
                  end
               end
               default: state_q <= HUNT;
            endcase
         end
      end
   end

   assign dec_out    = out_q;
   assign dec_ovld   = ovld_q;
   assign dec_err    = err_q;
   assign dec_locked = (state_q == LOCK);
   assign dec_errcnt = errcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cw_descrambler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cw_descrambler
//  Purpose  : Self-checking bench for cw_descrambler. Two instances share the
//             stimulus: u_dut (ECW=8) and u_dut2 (ECW=2, saturation checks).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cw_descrambler;

   logic       clk;
   logic       rst;
   logic [7:0] din;
   logic       vld;
   logic       sync;

   logic [3:0] out1, out2;
   logic       ovld1, ovld2, err1, err2, lck1, lck2;
   logic [7:0] ecnt1;
   logic [1:0] ecnt2;

   cw_descrambler #(.MAXERR(4), .ECW(8)) u_dut (
      .dec_clk(clk), .dec_rst(rst), .dec_in(din), .dec_vld(vld), .dec_sync(sync),
      .dec_out(out1), .dec_ovld(ovld1), .dec_err(err1), .dec_locked(lck1),
      .dec_errcnt(ecnt1)
   );

   cw_descrambler #(.MAXERR(4), .ECW(2)) u_dut2 (
      .dec_clk(clk), .dec_rst(rst), .dec_in(din), .dec_vld(vld), .dec_sync(sync),
      .dec_out(out2), .dec_ovld(ovld2), .dec_err(err2), .dec_locked(lck2),
      .dec_errcnt(ecnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       ovld;
      logic       err;
      logic [3:0] out;
      string      tag;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] cb [16];
   logic [7:0] bad_cw;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle at the falling edge, record the expected result, then
   // pop and compare it 1 time unit after the capturing rising edge.
   task automatic beat(input logic v, input logic s, input logic [7:0] d,
                       input logic eo, input logic ee, input logic [3:0] eout,
                       input string tag);
      exp_t e;
      @(negedge clk);
      vld  = v;
      sync = s;
      din  = d;
      sb.push_back('{ovld: eo, err: ee, out: eout, tag: tag});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({e.tag, ".ovld"}, 32'(ovld1), 32'(e.ovld));
      chk({e.tag, ".err"},  32'(err1),  32'(e.err));
      chk({e.tag, ".out"},  32'(out1),  32'(e.out));
   endtask

   initial begin
      cb = '{8'h1B, 8'h2D, 8'h36, 8'h47, 8'h59, 8'h6A, 8'h74, 8'h8E,
             8'h93, 8'hA5, 8'hB8, 8'hC6, 8'hD1, 8'hE3, 8'hF2, 8'h0F};
      rst = 1'b1; vld = 1'b0; sync = 1'b0; din = 8'h00;

      // 1. reset, no stimulus
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.out",    32'(out1),  32'h0);
      chk("rst.ovld",   32'(ovld1), 32'h0);
      chk("rst.err",    32'(err1),  32'h0);
      chk("rst.locked", 32'(lck1),  32'h0);
      chk("rst.errcnt", 32'(ecnt1), 32'h0);

      // 2. HUNT: non-sync beat dropped, sync beat locks
      beat(1, 0, cb[9], 0, 0, 4'h0, "hunt_nosync");
      chk("hunt_nosync.locked", 32'(lck1), 32'h0);
      beat(1, 1, cb[5], 1, 0, 4'h5, "hunt_sync");
      chk("hunt_sync.locked", 32'(lck1), 32'h1);

      // 3. LOCK stream of data 4'hA over 18 beats, with gaps, across K wrap
      for (int k = 0; k < 18; k++) begin
         beat(1, (k == 0), cb[4'hA ^ 4'(k)], 1, 0, 4'hA, $sformatf("strm%0d", k));
         if (k == 3 || k == 10 || k == 15) begin
            beat(0, 0, 8'h00, 0, 0, 4'hA, $sformatf("gap%0d", k));
         end
      end
      // K is now 2

      // 4. three invalids then a valid: still locked
      bad_cw = 8'h00;
      for (int i = 0; i < 3; i++) begin
         beat(1, 0, bad_cw, 1, 1, 4'h0, $sformatf("inv%0d", i));
         chk($sformatf("inv%0d.errcnt", i), 32'(ecnt1), 32'(i + 1));
      end
      beat(1, 0, cb[4'h3 ^ 4'h5], 1, 0, 4'h3, "recover");     // K = 5
      chk("recover.locked", 32'(lck1), 32'h1);
      chk("recover.errcnt", 32'(ecnt1), 32'h3);
      // MAXERR consecutive invalids drop lock on the 4th
      for (int i = 0; i < 4; i++) begin
         beat(1, 0, 8'h55, 1, 1, 4'h0, $sformatf("maxerr%0d", i));
         chk($sformatf("maxerr%0d.locked", i), 32'(lck1), 32'((i < 3) ? 1 : 0));
      end
      chk("maxerr.errcnt", 32'(ecnt1), 32'h7);
      beat(1, 0, cb[1], 0, 0, 4'h0, "after_unlock");
      chk("after_unlock.locked", 32'(lck1), 32'h0);

      // 5. re-align in LOCK at K=7
      beat(1, 1, cb[0], 1, 0, 4'h0, "relock");
      for (int k = 1; k < 7; k++) begin
         beat(1, 0, cb[4'hC ^ 4'(k)], 1, 0, 4'hC, $sformatf("pre%0d", k));
      end
      beat(1, 1, cb[2], 1, 0, 4'h2, "realign");
      beat(1, 0, cb[3], 1, 0, 4'h2, "post_realign");

      // mid-stream asynchronous reset while locked
      chk("pre_rst.locked", 32'(lck1), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst.ovld",   32'(ovld1), 32'h0);
      chk("async_rst.out",    32'(out1),  32'h0);
      chk("async_rst.locked", 32'(lck1),  32'h0);
      chk("async_rst.errcnt", 32'(ecnt1), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      // a non-sync valid beat must be dropped: FSM restarted in HUNT
      beat(1, 0, cb[6], 0, 0, 4'h0, "hunt_after_rst");

      // 6. invalid sync beats in HUNT: saturation in the narrow counter
      for (int i = 0; i < 5; i++) begin
         beat(1, 1, 8'hFF, 0, 1, 4'h0, $sformatf("hunterr%0d", i));
         chk($sformatf("hunterr%0d.errcnt8", i), 32'(ecnt1), 32'(i + 1));
         chk($sformatf("hunterr%0d.errcnt2", i), 32'(ecnt2), 32'((i < 3) ? i + 1 : 3));
         chk($sformatf("hunterr%0d.locked2", i), 32'(lck2), 32'h0);
      end

      @(negedge clk);
      vld = 1'b0; sync = 1'b0;
      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
